// File: rtl/jtag_tap_sysclk.sv
// JTAG TAP target clocked entirely by the SoC clock: TCK/TMS/TDI/TRST are oversampled
// and the 16-state TAP controller advances on detected TCK edges.
module jtag_tap_sysclk #(
    parameter logic [31:0] IdCode     = 32'h1000_0DB3,
    parameter int unsigned IrLen      = 5,
    parameter int unsigned DrWidth    = 32,
    parameter int unsigned SyncStages = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               jtag_tck_i,
    input  logic               jtag_tms_i,
    input  logic               jtag_trst_ni,
    input  logic               jtag_td_i,
    output logic               jtag_td_o,
    input  logic [DrWidth-1:0] user_capture_i,
    output logic [DrWidth-1:0] user_dr_o,
    output logic               user_update_o,
    output logic [3:0]         tap_state_o
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    localparam logic [IrLen-1:0] IrIdcode = IrLen'(1);
    localparam logic [IrLen-1:0] IrUser   = IrLen'(5'h10);

    logic [SyncStages-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
    logic tck_q, tck_rise, tck_fall;
    logic tck_s, tms_s, tdi_s, trst_s;

    tap_state_e           state_q, state_nxt;
    logic [IrLen-1:0]     ir_q, ir_shift;
    logic [31:0]          id_shift;
    logic [DrWidth-1:0]   user_shift;
    logic [DrWidth:0]     user_shift_in;
    logic                 byp_shift;
    logic                 sel_id, sel_user;

    assign tck_s  = tck_sync[SyncStages-1];
    assign tms_s  = tms_sync[SyncStages-1];
    assign tdi_s  = tdi_sync[SyncStages-1];
    assign trst_s = trst_sync[SyncStages-1];

    assign sel_id        = (ir_q == IrIdcode);
    assign sel_user      = (ir_q == IrUser) && !sel_id;
    assign user_shift_in = {tdi_s, user_shift};
    assign tap_state_o   = state_q;

    // IEEE 1149.1 next-state function; every 4-bit code is a legal state.
    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TLR:     tap_next = tms ? TLR    : RTI;
            RTI:     tap_next = tms ? SEL_DR : RTI;
            SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_next = tms ? UPD_DR : PA_DR;
            PA_DR:   tap_next = tms ? EX2_DR : PA_DR;
            EX2_DR:  tap_next = tms ? UPD_DR : SH_DR;
            UPD_DR:  tap_next = tms ? SEL_DR : RTI;
            SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_next = tms ? UPD_IR : PA_IR;
            PA_IR:   tap_next = tms ? EX2_IR : PA_IR;
            EX2_IR:  tap_next = tms ? UPD_IR : SH_IR;
            UPD_IR:  tap_next = tms ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

    assign state_nxt = tap_next(state_q, tms_s);

    // Pin synchronizers and registered TCK edge strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_q     <= 1'b0;
            tck_rise  <= 1'b0;
            tck_fall  <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[SyncStages-2:0], jtag_tck_i};
            tms_sync  <= {tms_sync[SyncStages-2:0], jtag_tms_i};
            tdi_sync  <= {tdi_sync[SyncStages-2:0], jtag_td_i};
            trst_sync <= {trst_sync[SyncStages-2:0], jtag_trst_ni};
            tck_q     <= tck_s;
            tck_rise  <= tck_s & ~tck_q;
            tck_fall  <= ~tck_s & tck_q;
        end
    end

    // TAP controller, instruction/data registers and TDO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= TLR;
            ir_q          <= IrIdcode;
            ir_shift      <= '0;
            id_shift      <= '0;
            user_shift    <= '0;
            byp_shift     <= 1'b0;
            jtag_td_o     <= 1'b0;
            user_dr_o     <= '0;
            user_update_o <= 1'b0;
        end else begin
            user_update_o <= 1'b0;
            if (!trst_s) begin
                state_q <= TLR;
                ir_q    <= IrIdcode;
            end else if (tck_rise) begin
                state_q <= state_nxt;
                if (state_q == SH_IR) begin
                    ir_shift <= {tdi_s, ir_shift[IrLen-1:1]};
                end
                if (state_q == SH_DR) begin
                    if (sel_id) begin
                        id_shift <= {tdi_s, id_shift[31:1]};
                    end else if (sel_user) begin
                        user_shift <= user_shift_in[DrWidth:1];
                    end else begin
                        byp_shift <= tdi_s;
                    end
                end
                // Actions tied to entering a state land together with the state change.
                case (state_nxt)
                    TLR:    ir_q     <= IrIdcode;
                    CAP_IR: ir_shift <= IrLen'(2'b01);
                    UPD_IR: ir_q     <= ir_shift;
                    CAP_DR: begin
                        if (sel_id) begin
                            id_shift <= IdCode;
                        end else if (sel_user) begin
                            user_shift <= user_capture_i;
                        end else begin
                            byp_shift <= 1'b0;
                        end
                    end
                    UPD_DR: begin
                        if (sel_user) begin
                            user_dr_o     <= user_shift;
                            user_update_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (tck_fall) begin
                if (state_q == SH_IR) begin
                    jtag_td_o <= ir_shift[0];
                end else if (state_q == SH_DR) begin
                    jtag_td_o <= sel_id ? id_shift[0] : (sel_user ? user_shift[0] : byp_shift);
                end else begin
                    jtag_td_o <= 1'b0;
                end
            end
        end
    end

endmodule
